// File: rtl/expr_pkg.sv
// Shared defaults and state encoding for the expression result collector.
package expr_pkg;

  localparam int          Y_W   = 90;
  localparam int          SIG_W = 32;
  localparam int          CNT_W = 16;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } expr_col_state_t;

endpackage

// File: rtl/expr_sig_step.sv
// One MISR step: fold the result vector into signature-width words and
// merge it into the shifted, polynomial-reduced signature.
module expr_sig_step
  import expr_pkg::*;
#(
  parameter int               Y_W   = expr_pkg::Y_W,
  parameter int               SIG_W = expr_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY  = expr_pkg::POLY
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [Y_W-1:0]   in_y,
  output logic [SIG_W-1:0] sig_next
);

  // Number of signature-width words after zero-extending the vector.
  localparam int NW = (Y_W + SIG_W - 1) / SIG_W;

  logic [NW*SIG_W-1:0] y_ext;
  logic [SIG_W-1:0]    fold;

  // XOR-fold the zero-extended vector, then apply the Galois shift.
  always_comb begin
    y_ext              = '0;
    y_ext[Y_W-1:0]     = in_y;
    fold               = '0;
    for (int i = 0; i < NW; i++) begin
      fold = fold ^ y_ext[i*SIG_W +: SIG_W];
    end
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end

endmodule

// File: rtl/expr_sig_collector.sv
// Captures a programmed number of result vectors into a MISR signature and
// compares the final signature against an expected value.
module expr_sig_collector
  import expr_pkg::*;
#(
  parameter int               Y_W   = expr_pkg::Y_W,
  parameter int               SIG_W = expr_pkg::SIG_W,
  parameter int               CNT_W = expr_pkg::CNT_W,
  parameter logic [SIG_W-1:0] POLY  = expr_pkg::POLY,
  parameter logic [SIG_W-1:0] SEED  = expr_pkg::SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] vec_cnt
);

  expr_col_state_t  state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             pass_q, pass_d;

  logic [SIG_W-1:0] sig_step;
  logic [CNT_W-1:0] cnt_inc;

  expr_sig_step #(
    .Y_W   (Y_W),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .sig      (sig_q),
    .in_y     (in_y),
    .sig_next (sig_step)
  );

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state, signature, counter and compare-result logic.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_vec;
          pass_d  = 1'b0;
          state_d = (num_vec == '0) ? FINAL : RUN;
        end
      end
      RUN: begin
        // in_ready is unconditionally high here, so in_valid alone accepts.
        if (in_valid) begin
          sig_d = sig_step;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        pass_d  = (sig_q == exp_sig);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      pass_q  <= pass_d;
    end
  end

  // Handshake and status decode purely from registered state.
  always_comb begin
    in_ready = (state_q == RUN);
    busy     = (state_q == RUN) || (state_q == FINAL);
    done     = (state_q == DONE);
    pass     = pass_q;
    sig      = sig_q;
    vec_cnt  = cnt_q;
  end

endmodule
